screenchar_write_arbiter: RTL and testbench

- Round-robin arbiter that shares the single write port of the screen character memory among several character producers, e.g. the status-digit writer, the terminal printer and the target-coordinate writer.
- Each producer requests the port, receives a one-hot grant, streams a burst of (char_index, char_data) beats, then releases the port.
- Outputs drive the memory's wraddress/data/wren directly, with one register stage.

---
 rtl/screenchar_write_arbiter.sv | 119 +++++++++++
 tb/tb_screenchar_write_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/screenchar_write_arbiter.sv
// Round-robin arbiter sharing the screen character memory write port among
// burst-oriented character producers; memory-side outputs are registered.
module screenchar_write_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16,
    localparam int OWNER_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        last,
    input  logic [NUM_REQ*ADDR_W-1:0] req_index,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic [OWNER_W-1:0]        owner,
    output logic [ADDR_W-1:0]         mem_wraddress,
    output logic [DATA_W-1:0]         mem_data,
    output logic                      mem_wren,
    output logic                      busy
);

    localparam int CNT_W = $clog2(MAX_BURST);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t             state;
    logic [OWNER_W-1:0] ptr;
    logic [CNT_W-1:0]   beat_cnt;

    logic               pick_found;
    logic [OWNER_W-1:0] pick_idx;
    logic [OWNER_W-1:0] cand;
    logic [ADDR_W-1:0]  owner_addr;
    logic [DATA_W-1:0]  owner_data;
    logic               owner_req;
    logic               owner_last;
    logic               burst_full;
    logic [OWNER_W-1:0] next_ptr;

    // Scan downward so the candidate closest to ptr is the one left standing.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = OWNER_W'((int'(ptr) + i) % NUM_REQ);
            if (req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        owner_addr = '0;
        owner_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (int'(owner) == i) begin
                owner_addr = req_index[i*ADDR_W +: ADDR_W];
                owner_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign owner_req  = req[owner];
    assign owner_last = last[owner];
    assign burst_full = (beat_cnt == CNT_W'(MAX_BURST - 1));
    assign next_ptr   = (int'(owner) == NUM_REQ - 1) ? '0 : owner + 1'b1;

    // Releasing the port always goes through IDLE, which guarantees the
    // mandatory grant-free cycle between bursts.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            ptr           <= '0;
            beat_cnt      <= '0;
            grant         <= '0;
            owner         <= '0;
            busy          <= 1'b0;
            mem_wraddress <= '0;
            mem_data      <= '0;
            mem_wren      <= 1'b0;
        end else begin
            mem_wren <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant    <= NUM_REQ'(1) << pick_idx;
                        owner    <= pick_idx;
                        beat_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (owner_req) begin
                        mem_wraddress <= owner_addr;
                        mem_data      <= owner_data;
                        mem_wren      <= 1'b1;
                        beat_cnt      <= beat_cnt + 1'b1;
                    end
                    if (!owner_req || owner_last || burst_full) begin
                        grant <= '0;
                        busy  <= 1'b0;
                        ptr   <= next_ptr;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_screenchar_write_arbiter.sv
// Self-checking bench for screenchar_write_arbiter: vector table, directed
// burst sequences and randomized traffic against a transaction-level model.
module tb_screenchar_write_arbiter;

    localparam int N  = 3;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int MB = 16;

    logic           clock = 1'b0;
    logic           resetn;
    logic [N-1:0]   req;
    logic [N-1:0]   last;
    logic [N*AW-1:0] req_index;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]   grant;
    logic [1:0]     owner;
    logic [AW-1:0]  mem_wraddress;
    logic [DW-1:0]  mem_data;
    logic           mem_wren;
    logic           busy;

    screenchar_write_arbiter #(
        .NUM_REQ  (N),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_BURST(MB)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .req          (req),
        .last         (last),
        .req_index    (req_index),
        .req_data     (req_data),
        .grant        (grant),
        .owner        (owner),
        .mem_wraddress(mem_wraddress),
        .mem_data     (mem_data),
        .mem_wren     (mem_wren),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model: who owns the port, how many beats it has written,
    // and where the next search starts.
    int            m_owner;
    int            m_cnt;
    int            m_ptr;
    int            e_owner;
    logic [N-1:0]  e_grant;
    logic          e_wren;
    logic          e_busy;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;

    logic [AW-1:0] wlog[$];
    logic [N-1:0]  glog[$];

    typedef struct {
        logic [N-1:0]    req;
        logic [N-1:0]    last;
        logic [N*AW-1:0] idx;
        logic [N*DW-1:0] dat;
        logic [N-1:0]    e_grant;
        logic [1:0]      e_owner;
        logic            e_wren;
        logic [AW-1:0]   e_addr;
        logic [DW-1:0]   e_data;
        logic            e_busy;
    } vec_t;

    vec_t vecs[10];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        m_owner = -1;
        m_cnt   = 0;
        m_ptr   = 0;
        e_owner = 0;
        e_grant = '0;
        e_wren  = 1'b0;
        e_busy  = 1'b0;
        e_addr  = '0;
        e_data  = '0;
    endtask

    task automatic modelStep(input logic [N-1:0] r, input logic [N-1:0] l,
                             input logic [N*AW-1:0] ix, input logic [N*DW-1:0] dt);
        int o;
        bit done;
        e_wren = 1'b0;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                o = (m_ptr + k) % N;
                if (m_owner < 0 && r[o]) begin
                    m_owner = o;
                    m_cnt   = 0;
                    e_owner = o;
                end
            end
        end else begin
            o    = m_owner;
            done = 1'b1;
            if (r[o]) begin
                e_wren = 1'b1;
                e_addr = ix[o*AW +: AW];
                e_data = dt[o*DW +: DW];
                m_cnt++;
                done = l[o] || (m_cnt == MB);
            end
            if (done) begin
                m_ptr   = (o + 1) % N;
                m_owner = -1;
            end
        end
        e_grant = '0;
        if (m_owner >= 0) e_grant[m_owner] = 1'b1;
        e_busy = (m_owner >= 0);
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, "_grant"}, grant, e_grant);
        checkOutput({tag, "_owner"}, owner, e_owner);
        checkOutput({tag, "_wren"}, mem_wren, e_wren);
        checkOutput({tag, "_busy"}, busy, e_busy);
        checkOutput({tag, "_addr"}, mem_wraddress, e_addr);
        checkOutput({tag, "_data"}, mem_data, e_data);
    endtask

    task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] l,
                                 input logic [N*AW-1:0] ix, input logic [N*DW-1:0] dt);
        req       = r;
        last      = l;
        req_index = ix;
        req_data  = dt;
        @(posedge clock);
        #1;
        if (resetn) modelStep(r, l, ix, dt);
        else        modelReset();
        if (mem_wren) wlog.push_back(mem_wraddress);
    endtask

    task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] l,
                         input logic [N*AW-1:0] ix, input logic [N*DW-1:0] dt, input string tag);
        applyStimulus(r, l, ix, dt);
        checkModel(tag);
    endtask

    task automatic doReset();
        resetn    = 1'b0;
        req       = '0;
        last      = '0;
        req_index = '0;
        req_data  = '0;
        @(posedge clock);
        #1;
        modelReset();
        checkModel("reset");
        resetn = 1'b1;
        wlog.delete();
        glog.delete();
    endtask

    // Producers raise req, stream beats only while granted, and flag last on their final beat.
    task automatic runProducers(input int b0, input int b1, input int b2, input int limit);
        int rem[N];
        int cnt[N];
        logic [N-1:0]    r;
        logic [N-1:0]    l;
        logic [N-1:0]    g;
        logic [N*AW-1:0] ix;
        logic [N*DW-1:0] dt;
        rem[0] = b0;
        rem[1] = b1;
        rem[2] = b2;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int c = 0; c < limit; c++) begin
            if (rem[0] + rem[1] + rem[2] == 0) break;
            r  = '0;
            l  = '0;
            ix = '0;
            dt = '0;
            g  = e_grant;
            for (int i = 0; i < N; i++) begin
                r[i] = (rem[i] > 0);
                l[i] = (rem[i] == 1);
                ix[i*AW +: AW] = AW'(32'hA0 + 32'h10 * i + cnt[i]);
                dt[i*DW +: DW] = DW'(32'h30 + cnt[i]);
            end
            cycle(r, l, ix, dt, "prod");
            for (int i = 0; i < N; i++) begin
                if (g[i] && r[i]) begin
                    rem[i]--;
                    cnt[i]++;
                end
            end
        end
        checkOutput("prod_done", rem[0] + rem[1] + rem[2], 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [N-1:0]    hold;
        logic [N-1:0]    l;
        logic [N-1:0]    exp_rr[6];

        vecs[0] = '{3'b010, 3'b000, 24'h000000, 24'h000000, 3'b010, 2'd1, 1'b0, 8'h00, 8'h00, 1'b1};
        vecs[1] = '{3'b010, 3'b000, 24'h005400, 24'h003100, 3'b010, 2'd1, 1'b1, 8'h54, 8'h31, 1'b1};
        vecs[2] = '{3'b010, 3'b000, 24'h005500, 24'h003200, 3'b010, 2'd1, 1'b1, 8'h55, 8'h32, 1'b1};
        vecs[3] = '{3'b010, 3'b010, 24'h005700, 24'h003300, 3'b000, 2'd1, 1'b1, 8'h57, 8'h33, 1'b0};
        vecs[4] = '{3'b000, 3'b000, 24'h000000, 24'h000000, 3'b000, 2'd1, 1'b0, 8'h57, 8'h33, 1'b0};
        vecs[5] = '{3'b101, 3'b000, 24'h000000, 24'h000000, 3'b100, 2'd2, 1'b0, 8'h57, 8'h33, 1'b1};
        vecs[6] = '{3'b101, 3'b100, 24'h100000, 24'h410000, 3'b000, 2'd2, 1'b1, 8'h10, 8'h41, 1'b0};
        vecs[7] = '{3'b101, 3'b101, 24'h000000, 24'h000000, 3'b001, 2'd0, 1'b0, 8'h10, 8'h41, 1'b1};
        vecs[8] = '{3'b001, 3'b001, 24'h000020, 24'h000050, 3'b000, 2'd0, 1'b1, 8'h20, 8'h50, 1'b0};
        vecs[9] = '{3'b000, 3'b000, 24'h000000, 24'h000000, 3'b000, 2'd0, 1'b0, 8'h20, 8'h50, 1'b0};

        doReset();
        for (int v = 0; v < 10; v++) begin
            applyStimulus(vecs[v].req, vecs[v].last, vecs[v].idx, vecs[v].dat);
            checkOutput($sformatf("vec%0d_grant", v), grant, vecs[v].e_grant);
            checkOutput($sformatf("vec%0d_owner", v), owner, vecs[v].e_owner);
            checkOutput($sformatf("vec%0d_wren", v), mem_wren, vecs[v].e_wren);
            checkOutput($sformatf("vec%0d_addr", v), mem_wraddress, vecs[v].e_addr);
            checkOutput($sformatf("vec%0d_data", v), mem_data, vecs[v].e_data);
            checkOutput($sformatf("vec%0d_busy", v), busy, vecs[v].e_busy);
        end

        $display("[TB] simultaneous requesters 0 and 2");
        doReset();
        runProducers(2, 0, 2, 30);
        cycle('0, '0, '0, '0, "prod_tail");
        checkOutput("sim_write_count", wlog.size(), 4);
        if (wlog.size() == 4) begin
            checkOutput("sim_w0", wlog[0], 8'hA0);
            checkOutput("sim_w1", wlog[1], 8'hA1);
            checkOutput("sim_w2", wlog[2], 8'hC0);
            checkOutput("sim_w3", wlog[3], 8'hC1);
        end

        $display("[TB] forced release");
        doReset();
        for (int b = 0; b < 17; b++)
            cycle(3'b001, 3'b000, {16'h0, 8'(b)}, {16'h0, 8'(8'h60 + b)}, "force");
        checkOutput("force_write_count", wlog.size(), 16);
        checkOutput("force_release_grant", grant, 3'b000);
        if (wlog.size() > 0) checkOutput("force_last_addr", wlog[wlog.size()-1], 8'd16);
        cycle(3'b001, 3'b000, '0, '0, "force_regrant");
        checkOutput("force_regrant_grant", grant, 3'b001);

        $display("[TB] request dropped mid-burst");
        doReset();
        for (int b = 0; b < 3; b++)
            cycle(3'b010, 3'b000, {8'h0, 8'(8'hE0 + b), 8'h0}, {8'h0, 8'(8'h70 + b), 8'h0}, "drop");
        cycle(3'b000, 3'b000, '0, '0, "drop_end");
        checkOutput("drop_wren", mem_wren, 1'b0);
        checkOutput("drop_grant", grant, 3'b000);
        checkOutput("drop_write_count", wlog.size(), 2);
        cycle(3'b101, 3'b000, '0, '0, "drop_next");
        checkOutput("drop_next_grant", grant, 3'b100);

        $display("[TB] continuous one-beat round robin");
        doReset();
        exp_rr = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        for (int c = 0; c < 12; c++) begin
            cycle(3'b111, 3'b111, '0, '0, "rr");
            if (grant != '0) glog.push_back(grant);
        end
        checkOutput("rr_grant_count", glog.size(), 6);
        if (glog.size() == 6)
            for (int k = 0; k < 6; k++) checkOutput($sformatf("rr_order%0d", k), glog[k], exp_rr[k]);

        $display("[TB] reset during a burst");
        doReset();
        cycle(3'b001, 3'b001, '0, '0, "mr_a");
        cycle(3'b001, 3'b001, 24'h000011, 24'h000022, "mr_b");
        cycle(3'b010, 3'b000, '0, '0, "mr_c");
        for (int b = 0; b < 4; b++)
            cycle(3'b010, 3'b000, {8'h0, 8'(8'h20 + b), 8'h0}, {8'h0, 8'(8'h40 + b), 8'h0}, "mr_beat");
        req_index = {8'h0, 8'h24, 8'h0};
        req_data  = {8'h0, 8'h44, 8'h0};
        #3;
        resetn = 1'b0;
        #1;
        checkOutput("mr_async_grant", grant, 3'b000);
        checkOutput("mr_async_wren", mem_wren, 1'b0);
        checkOutput("mr_async_busy", busy, 1'b0);
        modelReset();
        @(posedge clock);
        #1;
        checkOutput("mr_hold_wren", mem_wren, 1'b0);
        checkOutput("mr_write_count", wlog.size(), 5);
        resetn = 1'b1;
        cycle(3'b011, 3'b000, '0, '0, "mr_restart");
        checkOutput("mr_restart_grant", grant, 3'b001);

        $display("[TB] randomized traffic");
        doReset();
        hold = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(9) == 0) hold[i] = ~hold[i];
                l[i] = ($urandom_range(5) == 0);
            end
            cycle(hold, l, 24'($urandom), 24'($urandom), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
